// File: rtl/usb_nrzi_line_encoder_if.sv
// Serial transmit bus between the bit stuffer side and the NRZI line encoder.
// master = upstream driver, slave = encoder; state_dbg exposes the encoder FSM.
interface usb_nrzi_line_encoder_if;
    logic       in_bit;
    logic       in_valid;
    logic       eop_req;
    logic       dp;
    logic       dm;
    logic       tx_oe;
    logic       busy;
    logic       err;
    logic [1:0] state_dbg;

    modport master (
        output in_bit, in_valid, eop_req,
        input  dp, dm, tx_oe, busy, err, state_dbg
    );

    modport slave (
        input  in_bit, in_valid, eop_req,
        output dp, dm, tx_oe, busy, err, state_dbg
    );
endinterface

// File: rtl/usb_nrzi_line_encoder.sv
// USB transmit NRZI encoder with EOP (SE0 then J) generation and output-enable control.
// Define USB_NRZI_LOW_SPEED_EN to swap J/K polarity for low-speed signalling.
module usb_nrzi_line_encoder #(
    parameter int EOP_SE0_CYCLES = 2,
    parameter int EOP_J_CYCLES   = 1
) (
    input  logic                    clk,
    input  logic                    RST,
    usb_nrzi_line_encoder_if.slave  bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACTIVE  = 2'd1;
    localparam logic [1:0] S_EOP_SE0 = 2'd2;
    localparam logic [1:0] S_EOP_J   = 2'd3;

    localparam logic [2:0] SE0_LOAD = 3'(EOP_SE0_CYCLES - 1);
    localparam logic [2:0] J_LOAD   = 3'(EOP_J_CYCLES - 1);

`ifdef USB_NRZI_LOW_SPEED_EN
    localparam logic J_DP = 1'b0;
`else
    localparam logic J_DP = 1'b1;
`endif

    logic [1:0] state_q, state_d;
    logic       level_q, level_d;   // 0 = J, 1 = K
    logic [2:0] cnt_q, cnt_d;
    logic       dp_q, dp_d;
    logic       dm_q, dm_d;
    logic       oe_q, oe_d;
    logic       err_q, err_d;
    logic       drive_k;
    logic       drive_se0;

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        oe_d      = 1'b1;
        drive_k   = 1'b0;
        drive_se0 = 1'b0;
        case (state_q)
            S_IDLE: begin
                err_d = bus.eop_req;
                oe_d  = 1'b0;
                // First bit is encoded against the idle J reference.
                if (bus.in_valid) begin
                    state_d = S_ACTIVE;
                    level_d = ~bus.in_bit;
                    drive_k = ~bus.in_bit;
                    oe_d    = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (bus.in_valid && !bus.in_bit) begin
                    level_d = ~level_q;
                end
                drive_k = level_d;
                if (bus.eop_req) begin
                    state_d = S_EOP_SE0;
                    cnt_d   = SE0_LOAD;
                end
            end
            S_EOP_SE0: begin
                drive_se0 = 1'b1;
                err_d     = bus.in_valid;
                if (cnt_q == 3'd0) begin
                    state_d = S_EOP_J;
                    cnt_d   = J_LOAD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_EOP_J: begin
                err_d = bus.in_valid;
                if (cnt_q == 3'd0) begin
                    state_d = S_IDLE;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                level_d = 1'b0;
                cnt_d   = 3'd0;
                oe_d    = 1'b0;
            end
        endcase
        dp_d = drive_se0 ? 1'b0 : (drive_k ? ~J_DP : J_DP);
        dm_d = drive_se0 ? 1'b0 : (drive_k ? J_DP : ~J_DP);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= S_IDLE;
            level_q <= 1'b0;
            cnt_q   <= 3'd0;
            dp_q    <= J_DP;
            dm_q    <= ~J_DP;
            oe_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            dp_q    <= dp_d;
            dm_q    <= dm_d;
            oe_q    <= oe_d;
            err_q   <= err_d;
        end
    end

    assign bus.dp        = dp_q;
    assign bus.dm        = dm_q;
    assign bus.tx_oe     = oe_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_usb_nrzi_line_encoder.sv
// Bench for usb_nrzi_line_encoder: default-parameter DUT and an EOP 3/2 DUT share one stimulus stream.
module tb_usb_nrzi_line_encoder;
`ifdef USB_NRZI_LOW_SPEED_EN
    localparam logic [1:0] LJ = 2'b01;
    localparam logic [1:0] LK = 2'b10;
`else
    localparam logic [1:0] LJ = 2'b10;
    localparam logic [1:0] LK = 2'b01;
`endif
    localparam logic [1:0] SE0 = 2'b00;

    logic clk = 1'b0;
    logic rst_s = 1'b1;
    logic in_bit_s = 1'b0;
    logic in_valid_s = 1'b0;
    logic eop_req_s = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    usb_nrzi_line_encoder_if bus0 ();
    usb_nrzi_line_encoder_if bus1 ();

    assign bus0.in_bit   = in_bit_s;
    assign bus0.in_valid = in_valid_s;
    assign bus0.eop_req  = eop_req_s;
    assign bus1.in_bit   = in_bit_s;
    assign bus1.in_valid = in_valid_s;
    assign bus1.eop_req  = eop_req_s;

    usb_nrzi_line_encoder dut0 (
        .clk (clk),
        .RST (rst_s),
        .bus (bus0.slave)
    );

    usb_nrzi_line_encoder #(.EOP_SE0_CYCLES(3), .EOP_J_CYCLES(2)) dut1 (
        .clk (clk),
        .RST (rst_s),
        .bus (bus1.slave)
    );

    // Observed vector per DUT: {dp, dm, tx_oe, busy, err}
    logic [4:0] act_vec [2];
    assign act_vec[0] = {bus0.dp, bus0.dm, bus0.tx_oe, bus0.busy, bus0.err};
    assign act_vec[1] = {bus1.dp, bus1.dm, bus1.tx_oe, bus1.busy, bus1.err};

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got {dp,dm,oe,busy,err}=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a packet is either idle, carrying bits, or playing out
    // a fixed number of remaining SE0 and J bit times.
    int         se0_n [2] = '{2, 3};
    int         j_n   [2] = '{1, 2};
    bit         in_pkt [2];
    bit         is_k [2];
    int         se0_left [2];
    int         j_left [2];
    logic [4:0] exp_vec [2];

    task automatic model_step(input int i);
        logic [1:0] line;
        logic       oe;
        logic       e;
        bit         was;
        line = LJ;
        oe   = 1'b0;
        e    = 1'b0;
        if (rst_s) begin
            in_pkt[i] = 0; is_k[i] = 0; se0_left[i] = 0; j_left[i] = 0;
        end else if (se0_left[i] > 0) begin
            se0_left[i]--;
            line = SE0; oe = 1'b1; e = in_valid_s;
        end else if (j_left[i] > 0) begin
            j_left[i]--;
            line = LJ; oe = 1'b1; e = in_valid_s;
        end else if (in_pkt[i] || in_valid_s) begin
            was = in_pkt[i];
            e = eop_req_s && !was;
            if (in_valid_s && !in_bit_s) is_k[i] = !is_k[i];
            in_pkt[i] = 1;
            line = is_k[i] ? LK : LJ;
            oe = 1'b1;
            if (eop_req_s && was) begin
                se0_left[i] = se0_n[i];
                j_left[i]   = j_n[i];
                in_pkt[i]   = 0;
                is_k[i]     = 0;
            end
        end else begin
            e = eop_req_s;
        end
        exp_vec[i] = {line, oe, (in_pkt[i] || se0_left[i] > 0 || j_left[i] > 0), e};
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
        #2;
        for (int i = 0; i < 2; i++) chk($sformatf("model_dut%0d", i), act_vec[i], exp_vec[i]);
    end

    task automatic drive(input logic v, input logic b, input logic e, input logic r);
        @(negedge clk);
        in_valid_s = v;
        in_bit_s   = b;
        eop_req_s  = e;
        rst_s      = r;
    endtask

    // Drive one cycle and check dut0 against a hand-derived literal.
    task automatic dchk(input logic v, input logic b, input logic e, input logic r,
                        input logic [1:0] line, input logic oe, input logic busy,
                        input logic err, input string name);
        drive(v, b, e, r);
        @(posedge clk);
        #3;
        chk(name, act_vec[0], {line, oe, busy, err});
    endtask

    initial begin
        logic [1:0] d0_line [6];
        logic [1:0] d1_line [6];
        logic       d0_oe [6];
        logic       d1_oe [6];
        logic [5:0] enc_bits;
        logic [1:0] enc_exp [6];

        dchk(0, 0, 0, 1, LJ, 0, 0, 0, "rst_a");
        dchk(0, 0, 0, 1, LJ, 0, 0, 0, "rst_b");

        enc_bits = 6'b100110;
        enc_exp  = '{LJ, LK, LJ, LJ, LJ, LK};
        for (int k = 0; k < 6; k++)
            dchk(1, enc_bits[5-k], 0, 0, enc_exp[k], 1, 1, 0, $sformatf("enc%0d", k));

        for (int k = 0; k < 3; k++) dchk(0, 0, 0, 0, LK, 1, 1, 0, "gap_hold_k");

        dchk(1, 0, 0, 0, LJ, 1, 1, 0, "pre_eop");
        dchk(1, 0, 1, 0, LK, 1, 1, 0, "eop_with_bit");

        d0_line = '{SE0, SE0, LJ, LJ, LJ, LJ};
        d0_oe   = '{1, 1, 1, 0, 0, 0};
        d1_line = '{SE0, SE0, SE0, LJ, LJ, LJ};
        d1_oe   = '{1, 1, 1, 1, 1, 0};
        for (int k = 0; k < 6; k++) begin
            drive(k == 0, 1'b1, 1'b0, 1'b0);
            @(posedge clk);
            #3;
            chk($sformatf("eop_dut0_%0d", k), act_vec[0], {d0_line[k], d0_oe[k], (k < 2), (k == 0)});
            chk($sformatf("eop_dut1_%0d", k), act_vec[1], {d1_line[k], d1_oe[k], (k < 4), (k == 0)});
        end

        dchk(0, 0, 1, 0, LJ, 0, 0, 1, "idle_eop_err");
        dchk(0, 0, 0, 0, LJ, 0, 0, 0, "err_clear");

        dchk(1, 0, 0, 0, LK, 1, 1, 0, "to_k");
        dchk(0, 0, 0, 1, LJ, 0, 0, 0, "rst_mid_a");
        dchk(0, 0, 0, 1, LJ, 0, 0, 0, "rst_mid_b");
        dchk(0, 0, 0, 0, LJ, 0, 0, 0, "after_rst");

        for (int p = 0; p < 200; p++) begin
            int  gap;
            int  len;
            int  tail;
            bit  eop_last;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) drive(0, 0, $urandom_range(0, 7) == 0, 0);
            len      = $urandom_range(1, 12);
            eop_last = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) drive(0, 0, 0, 0);
                drive(1, 1'($urandom_range(0, 1)), (k == len - 1) && eop_last,
                      $urandom_range(0, 199) == 0);
            end
            if (!eop_last) drive(0, 0, 1, 0);
            tail = $urandom_range(0, 6);
            for (int t = 0; t < tail; t++)
                drive($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 4) == 0, 0);
        end

        for (int k = 0; k < 8; k++) drive(0, 0, 0, 0);
        @(posedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
